// File: rtl/clk_rst_seq.sv
// Reset and clock-enable sequencer for the MMCM output domain: qualifies `locked`,
// releases channel resets in staggered order and runs one clock-enable divider per channel.
module clk_rst_seq #(
    parameter int NUM_CH        = 4,
    parameter int STABLE_CYCLES = 256,
    parameter int STAGGER       = 16,
    parameter int DIV_W         = 8,
    parameter int CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      locked_in,
    input  logic [NUM_CH*DIV_W-1:0]   div_ratio,
    output logic [NUM_CH-1:0]         rst_out,
    output logic [NUM_CH-1:0]         ce_out,
    output logic                      ready,
    output logic [CNT_W-1:0]          lock_loss_cnt,
    output logic [1:0]                state
);

    localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int GW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int IW = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t              state_r;
    logic [1:0]          sync_r;
    logic                locked_s;
    logic [SW-1:0]       stable_cnt_r;
    logic [GW-1:0]       stag_cnt_r;
    logic [IW-1:0]       idx_r;
    logic [NUM_CH-1:0]   rst_out_r;
    logic                ready_r;
    logic [CNT_W-1:0]    loss_cnt_r;
    logic                lock_lost_s;
    logic                release_s;
    logic [NUM_CH-1:0]   rel_vec_s;

    assign locked_s      = sync_r[1];
    assign rst_out       = rst_out_r;
    assign ready         = ready_r;
    assign lock_loss_cnt = loss_cnt_r;
    assign state         = state_r;

    // Two-flop synchroniser for the asynchronous MMCM locked flag
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], locked_in};
        end
    end

    // Lock-loss and per-channel release strobes; lock loss suppresses any release
    always_comb begin
        lock_lost_s = 1'b0;
        release_s   = 1'b0;
        rel_vec_s   = '0;
        if ((state_r == RELEASE) || (state_r == RUN)) begin
            lock_lost_s = ~locked_s;
        end else begin
            lock_lost_s = 1'b0;
        end
        if ((state_r == RELEASE) && locked_s && (stag_cnt_r == GW'(STAGGER - 1))
            && (idx_r != IW'(NUM_CH))) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            rel_vec_s[i] = release_s && (idx_r == IW'(i));
        end
    end

    // Sequencer FSM with registered reset, ready and lock-loss outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= WAIT_LOCK;
            stable_cnt_r <= '0;
            stag_cnt_r   <= '0;
            idx_r        <= '0;
            rst_out_r    <= '1;
            ready_r      <= 1'b0;
            loss_cnt_r   <= '0;
        end else if (lock_lost_s) begin
            state_r    <= WAIT_LOCK;
            rst_out_r  <= '1;
            ready_r    <= 1'b0;
            stag_cnt_r <= '0;
            idx_r      <= '0;
            if (loss_cnt_r != {CNT_W{1'b1}}) begin
                loss_cnt_r <= loss_cnt_r + CNT_W'(1);
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
        end else begin
            case (state_r)
                WAIT_LOCK: begin
                    rst_out_r    <= '1;
                    ready_r      <= 1'b0;
                    stable_cnt_r <= '0;
                    if (locked_s) begin
                        state_r <= STABLE;
                    end else begin
                        state_r <= WAIT_LOCK;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_r <= WAIT_LOCK;
                    end else if (stable_cnt_r == SW'(STABLE_CYCLES - 1)) begin
                        state_r    <= RELEASE;
                        stag_cnt_r <= '0;
                        idx_r      <= '0;
                    end else begin
                        stable_cnt_r <= stable_cnt_r + SW'(1);
                    end
                end
                RELEASE: begin
                    if (idx_r == IW'(NUM_CH)) begin
                        state_r <= RUN;
                        ready_r <= 1'b1;
                    end else if (release_s) begin
                        rst_out_r  <= rst_out_r & ~rel_vec_s;
                        idx_r      <= idx_r + IW'(1);
                        stag_cnt_r <= '0;
                    end else begin
                        stag_cnt_r <= stag_cnt_r + GW'(1);
                    end
                end
                RUN: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= WAIT_LOCK;
                    rst_out_r <= '1;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] ratio_r;
        logic [DIV_W-1:0] cnt_r;
        logic [DIV_W-1:0] period_m1_s;
        logic             ce_r;

        assign ce_out[i] = ce_r;

        // Terminal count of the divider; a zero ratio behaves like one
        always_comb begin
            if (ratio_r == '0) begin
                period_m1_s = '0;
            end else begin
                period_m1_s = ratio_r - DIV_W'(1);
            end
        end

        // Divider: first pulse on the release edge, ratio re-sampled on every pulse
        always_ff @(posedge clk) begin
            if (rst || lock_lost_s) begin
                cnt_r   <= '0;
                ce_r    <= 1'b0;
                ratio_r <= '0;
            end else if (rel_vec_s[i]) begin
                cnt_r   <= '0;
                ce_r    <= 1'b1;
                ratio_r <= div_ratio[i*DIV_W +: DIV_W];
            end else if (rst_out_r[i]) begin
                cnt_r   <= '0;
                ce_r    <= 1'b0;
                ratio_r <= ratio_r;
            end else if (cnt_r == period_m1_s) begin
                cnt_r   <= '0;
                ce_r    <= 1'b1;
                ratio_r <= div_ratio[i*DIV_W +: DIV_W];
            end else begin
                cnt_r   <= cnt_r + DIV_W'(1);
                ce_r    <= 1'b0;
                ratio_r <= ratio_r;
            end
        end
    end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed self-checking bench for clk_rst_seq (NUM_CH=4, STABLE_CYCLES=8, STAGGER=4, CNT_W=2).
module tb_clk_rst_seq;

    logic        clk;
    logic        rst;
    logic        locked_in;
    logic [31:0] div_ratio;
    logic [3:0]  rst_out;
    logic [3:0]  ce_out;
    logic        ready;
    logic [1:0]  lock_loss_cnt;
    logic [1:0]  state;

    int vectors;
    int miscompares;

    clk_rst_seq #(
        .NUM_CH(4), .STABLE_CYCLES(8), .STAGGER(4), .DIV_W(8), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .locked_in(locked_in), .div_ratio(div_ratio),
        .rst_out(rst_out), .ce_out(ce_out), .ready(ready),
        .lock_loss_cnt(lock_loss_cnt), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise locked at edge E (now) and follow the full release timeline up to E+28
    task automatic lock_up(input logic [1:0] exp_cnt);
        locked_in = 1'b1;
        step(2);  chk("e2_state", state, 0);
        step(1);  chk("e3_state", state, 1);
        step(7);  chk("e10_state", state, 1);
        step(1);  chk("e11_state", state, 2);  chk("e11_rst", rst_out, 4'hF);
        step(3);  chk("e14_rst", rst_out, 4'hF);
        step(1);  chk("e15_rst", rst_out, 4'hE);  chk("e15_ce", ce_out, 4'b0001);
        step(4);  chk("e19_rst", rst_out, 4'hC);  chk("e19_ce", ce_out, 4'b0011);
        step(4);  chk("e23_rst", rst_out, 4'h8);  chk("e23_ce", ce_out, 4'b0101);
        step(4);  chk("e27_rst", rst_out, 4'h0);  chk("e27_ce", ce_out, 4'b1101);
                  chk("e27_ready", ready, 0);
        step(1);  chk("e28_ready", ready, 1);  chk("e28_state", state, 3);
                  chk("e28_ce", ce_out, 4'b0111);  chk("e28_cnt", lock_loss_cnt, exp_cnt);
    endtask

    // Drop locked at edge F (now) and check the forced re-reset at F+3
    task automatic lose_lock(input logic [1:0] exp_cnt);
        locked_in = 1'b0;
        step(2);  chk("f2_rst", rst_out, 4'h0);  chk("f2_ready", ready, 1);
        step(1);  chk("f3_rst", rst_out, 4'hF);  chk("f3_ready", ready, 0);
                  chk("f3_ce", ce_out, 4'h0);    chk("f3_state", state, 0);
                  chk("f3_cnt", lock_loss_cnt, exp_cnt);
    endtask

    initial begin
        int t;
        logic [3:0] exp_ce;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        locked_in   = 1'b0;
        div_ratio   = {8'd5, 8'd0, 8'd3, 8'd1};

        // Reset state
        step(5);
        chk("rst_rst_out", rst_out, 4'hF);  chk("rst_ce", ce_out, 4'h0);
        chk("rst_ready", ready, 0);         chk("rst_cnt", lock_loss_cnt, 0);
        chk("rst_state", state, 0);
        rst = 1'b0;
        step(3);
        chk("idle_state", state, 0);  chk("idle_rst", rst_out, 4'hF);

        // Glitch during STABLE: 5 high, 2 low, then full sequence from the second rise
        locked_in = 1'b1;
        step(5);  chk("g5_state", state, 1);  chk("g5_rst", rst_out, 4'hF);
        locked_in = 1'b0;
        step(2);  chk("g7_state", state, 1);  chk("g7_rst", rst_out, 4'hF);
        step(0);
        lock_up(2'd0);

        // Dividers in RUN: ch0/ch2 every cycle, ch1 1-of-3 from E+19, ch3 1-of-5 from E+27
        t = 28;
        for (int k = 0; k < 15; k++) begin
            step(1);
            t++;
            exp_ce = {((t - 27) % 5 == 0), 1'b1, ((t - 19) % 3 == 0), 1'b1};
            chk("div_run", ce_out, exp_ce);
        end
        // t = 43 is a ch1 pulse; the new ratio only applies from the pulse at 46
        div_ratio[15:8] = 8'd2;
        for (int k = 0; k < 8; k++) begin
            step(1);
            t++;
            chk("div_change", ce_out[1], (t == 46) || (t == 48) || (t == 50));
        end
        div_ratio[15:8] = 8'd3;

        // Lock loss in RUN, then relock with the same timing
        lose_lock(2'd1);
        lock_up(2'd1);

        // Saturating lock-loss counter (CNT_W=2)
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("sat_clear", lock_loss_cnt, 0);
        for (int k = 1; k <= 5; k++) begin
            lock_up((k - 1 > 3) ? 2'd3 : 2'(k - 1));
            lose_lock((k > 3) ? 2'd3 : 2'(k));
        end

        // Reset while two channels are already released
        locked_in = 1'b1;
        step(19);
        chk("mid_rst_pre", rst_out, 4'hC);
        rst = 1'b1;
        step(1);
        chk("mid_rst_out", rst_out, 4'hF);  chk("mid_state", state, 0);
        chk("mid_ready", ready, 0);         chk("mid_cnt", lock_loss_cnt, 0);
        chk("mid_ce", ce_out, 4'h0);
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
